// File: rtl/sdram_port_ctrl_pkg.sv
// Shared types and constants for the SDRAM port manager.
package sdram_port_ctrl_pkg;

  localparam int unsigned SDRAM_AW      = 24;
  localparam int unsigned SDRAM_DW      = 16;
  localparam int unsigned DEF_BURST_LEN = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_XFER = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_XFER = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR_REQ  = ST_WR_REQ,
    WR_XFER = ST_WR_XFER,
    RD_REQ  = ST_RD_REQ,
    RD_XFER = ST_RD_XFER
  } state_e;

endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock show-ahead FIFO with fill count; head reads 0 while empty.
module sdram_sync_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (fill == CW'(DEPTH));
  assign empty   = (fill == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sdram_port_ctrl.sv
// Buffers user write/read streams and issues round-robin burst requests to the SDRAM controller.
module sdram_port_ctrl
  import sdram_port_ctrl_pkg::*;
#(
  parameter int unsigned         BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned         FIFO_DEPTH = 32,
  parameter logic [SDRAM_AW-1:0] ADDR_MIN   = 24'd0,
  parameter logic [SDRAM_AW-1:0] ADDR_MAX   = 24'd1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [SDRAM_DW-1:0] wr_data,
  output logic                wr_full,
  input  logic                rd_en,
  output logic [SDRAM_DW-1:0] rd_data,
  output logic                rd_empty,
  input  logic                rd_enable,
  input  logic                sdram_init_done,
  output logic                sdram_wr_req,
  input  logic                sdram_wr_ack,
  output logic [SDRAM_AW-1:0] sdram_wr_addr,
  output logic [SDRAM_DW-1:0] sdram_din,
  output logic                sdram_rd_req,
  input  logic                sdram_rd_ack,
  output logic [SDRAM_AW-1:0] sdram_rd_addr,
  input  logic [SDRAM_DW-1:0] sdram_dout
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW  = $clog2(BURST_LEN) + 1;
  localparam int unsigned AW1 = SDRAM_AW + 1;

  state_e        state;
  logic          last_grant_rd;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] wr_fill;
  logic [CW-1:0] rd_fill;
  logic          wr_beat;
  logic          rd_beat;
  logic          wr_elig;
  logic          rd_elig;
  logic          grant_wr;
  logic          grant_rd;

  // The first ack arrives while still in *_REQ and already moves a word.
  assign wr_beat  = sdram_wr_ack && (state == WR_REQ || state == WR_XFER);
  assign rd_beat  = sdram_rd_ack && (state == RD_REQ || state == RD_XFER);
  assign wr_elig  = sdram_init_done && (wr_fill >= CW'(BURST_LEN));
  assign rd_elig  = sdram_init_done && rd_enable &&
                    ((CW'(FIFO_DEPTH) - rd_fill) >= CW'(BURST_LEN));
  assign grant_wr = wr_elig && (!rd_elig || last_grant_rd);
  assign grant_rd = rd_elig && !grant_wr;

  assign wr_full  = (wr_fill == CW'(FIFO_DEPTH));
  assign rd_empty = (rd_fill == '0);

  function automatic logic [SDRAM_AW-1:0] next_addr(input logic [SDRAM_AW-1:0] a);
    logic [SDRAM_AW:0] n;
    n = {1'b0, a} + AW1'(BURST_LEN);
    return (n >= {1'b0, ADDR_MAX}) ? ADDR_MIN : n[SDRAM_AW-1:0];
  endfunction

  sdram_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SDRAM_DW)) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (wr_beat),
    .head      (sdram_din),
    .fill      (wr_fill)
  );

  sdram_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SDRAM_DW)) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_beat),
    .push_data (sdram_dout),
    .pop       (rd_en),
    .head      (rd_data),
    .fill      (rd_fill)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant_rd <= 1'b1;
      beat_cnt      <= '0;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= ADDR_MIN;
      sdram_rd_addr <= ADDR_MIN;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (grant_wr) begin
            state         <= WR_REQ;
            sdram_wr_req  <= 1'b1;
            last_grant_rd <= 1'b0;
          end else if (grant_rd) begin
            state         <= RD_REQ;
            sdram_rd_req  <= 1'b1;
            last_grant_rd <= 1'b1;
          end
        end
        WR_REQ: begin
          if (sdram_wr_ack) begin
            state        <= WR_XFER;
            sdram_wr_req <= 1'b0;
            beat_cnt     <= beat_cnt + BW'(1);
          end
        end
        WR_XFER: begin
          if (sdram_wr_ack) begin
            beat_cnt <= beat_cnt + BW'(1);
          end else begin
            state         <= IDLE;
            sdram_wr_addr <= next_addr(sdram_wr_addr);
          end
        end
        RD_REQ: begin
          if (sdram_rd_ack) begin
            state        <= RD_XFER;
            sdram_rd_req <= 1'b0;
            beat_cnt     <= beat_cnt + BW'(1);
          end
        end
        RD_XFER: begin
          if (sdram_rd_ack) begin
            beat_cnt <= beat_cnt + BW'(1);
          end else begin
            state         <= IDLE;
            sdram_rd_addr <= next_addr(sdram_rd_addr);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A burst must end after exactly BURST_LEN ack cycles.
  always_ff @(posedge clk) begin
    if (rst_n && ((state == WR_XFER && !sdram_wr_ack) || (state == RD_XFER && !sdram_rd_ack)))
      assert (beat_cnt == BW'(BURST_LEN));
  end

endmodule

// File: tb/tb_sdram_port_ctrl.sv
// Directed self-checking bench for sdram_port_ctrl, with a wrap-region second instance.
module tb_sdram_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, wr_full, rd_en, rd_empty, rd_enable, init_done;
  logic        wr_req, wr_ack, rd_req, rd_ack;
  logic [15:0] wr_data, rd_data, din, dout;
  logic [23:0] wr_addr, rd_addr;

  logic        w_rst_n, w_wr_en, w_wr_full, w_rd_empty, w_init, w_wr_req, w_wr_ack, w_rd_req;
  logic [15:0] w_wr_data, w_rd_data, w_din;
  logic [23:0] w_wr_addr, w_rd_addr;

  int checks = 0;
  int failures = 0;

  sdram_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_enable(rd_enable),
    .sdram_init_done(init_done), .sdram_wr_req(wr_req), .sdram_wr_ack(wr_ack),
    .sdram_wr_addr(wr_addr), .sdram_din(din), .sdram_rd_req(rd_req), .sdram_rd_ack(rd_ack),
    .sdram_rd_addr(rd_addr), .sdram_dout(dout)
  );

  sdram_port_ctrl #(.BURST_LEN(8), .ADDR_MAX(24'd16)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .wr_en(w_wr_en), .wr_data(w_wr_data), .wr_full(w_wr_full),
    .rd_en(1'b0), .rd_data(w_rd_data), .rd_empty(w_rd_empty), .rd_enable(1'b0),
    .sdram_init_done(w_init), .sdram_wr_req(w_wr_req), .sdram_wr_ack(w_wr_ack),
    .sdram_wr_addr(w_wr_addr), .sdram_din(w_din), .sdram_rd_req(w_rd_req), .sdram_rd_ack(1'b0),
    .sdram_rd_addr(w_rd_addr), .sdram_dout(16'h0000)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_rst_n = 1'b0;
    tick(); tick();
    checks++; if (wr_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req got=%0b exp=0", wr_req); end
    checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req got=%0b exp=0", rd_req); end
    checks++; if (wr_full !== 1'b0 || rd_empty !== 1'b1) begin failures++; $display("FAIL reset_flags got full=%0b empty=%0b exp full=0 empty=1", wr_full, rd_empty); end
    checks++; if (wr_addr !== 24'd0 || rd_addr !== 24'd0) begin failures++; $display("FAIL reset_addr got wr=%0h rd=%0h exp 0", wr_addr, rd_addr); end
    checks++; if (din !== 16'h0 || rd_data !== 16'h0) begin failures++; $display("FAIL reset_data got din=%0h rd_data=%0h exp 0", din, rd_data); end
    rst_n = 1'b1; w_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_init_gate();
    logic found;
    init_done = 1'b0; rd_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin wr_en = 1'b1; wr_data = 16'(i + 1); tick(); end
    wr_en = 1'b0;
    repeat (4) tick();
    checks++; if (wr_req !== 1'b0) begin failures++; $display("FAIL init_gate_no_req got=%0b exp=0", wr_req); end
    checks++; if (din !== 16'h0001) begin failures++; $display("FAIL init_gate_head got=%0h exp=0001", din); end
    init_done = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2 && !found; c++) begin tick(); if (wr_req === 1'b1) found = 1'b1; end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL init_gate_req got=%0b exp=1", found); end
    checks++; if (wr_addr !== 24'd0) begin failures++; $display("FAIL init_gate_addr got=%0h exp=0", wr_addr); end
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 8; i++) begin
      wr_ack = 1'b1;
      checks++; if (din !== 16'(i + 1)) begin failures++; $display("FAIL wr_burst_din[%0d] got=%0h exp=%0h", i, din, 16'(i + 1)); end
      tick();
    end
    wr_ack = 1'b0;
    tick();
    checks++; if (wr_addr !== 24'd8) begin failures++; $display("FAIL wr_burst_next_addr got=%0h exp=8", wr_addr); end
    checks++; if (dut.wr_fill !== 6'd0) begin failures++; $display("FAIL wr_burst_fill got=%0d exp=0", dut.wr_fill); end
    checks++; if (din !== 16'h0) begin failures++; $display("FAIL wr_burst_empty_head got=%0h exp=0", din); end
    repeat (3) tick();
    checks++; if (wr_req !== 1'b0) begin failures++; $display("FAIL wr_burst_no_rereq got=%0b exp=0", wr_req); end
  endtask

  task automatic read_burst(input int base, input logic [23:0] exp_addr);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 4; c++) begin if (rd_req === 1'b1) begin got = 1'b1; break; end tick(); end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL rd_req_timeout got=%0b exp=1 addr=%0h", got, exp_addr); end
    checks++; if (rd_addr !== exp_addr) begin failures++; $display("FAIL rd_addr got=%0h exp=%0h", rd_addr, exp_addr); end
    if (got) begin
      for (int i = 0; i < 8; i++) begin rd_ack = 1'b1; dout = 16'hA000 + 16'(base + i); tick(); end
      rd_ack = 1'b0;
      tick();
    end
  endtask

  task automatic test_read_prefetch();
    rd_enable = 1'b1;
    for (int b = 0; b < 4; b++) read_burst(b * 8, 24'(b * 8));
    repeat (5) tick();
    checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL rd_full_stall got=%0b exp=0", rd_req); end
    checks++; if (dut.rd_fill !== 6'd32) begin failures++; $display("FAIL rd_full_fill got=%0d exp=32", dut.rd_fill); end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      checks++; if (rd_data !== 16'hA000 + 16'(i)) begin failures++; $display("FAIL rd_drain[%0d] got=%0h exp=%0h", i, rd_data, 16'hA000 + 16'(i)); end
      tick();
    end
    rd_en = 1'b0;
    read_burst(32, 24'd32);
    rd_enable = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1;
      checks++; if (rd_data !== 16'hA008 + 16'(i)) begin failures++; $display("FAIL rd_seq[%0d] got=%0h exp=%0h", i, rd_data, 16'hA008 + 16'(i)); end
      tick();
    end
    rd_en = 1'b0;
    checks++; if (rd_empty !== 1'b1 || rd_data !== 16'h0) begin failures++; $display("FAIL rd_final_empty got empty=%0b data=%0h exp 1/0", rd_empty, rd_data); end
  endtask

  task automatic test_arbitration();
    logic        exp_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [23:0] exp_a [4] = '{24'd0, 24'd0, 24'd8, 24'd8};
    logic        got;
    int          wexp;
    do_reset();
    init_done = 1'b0;
    for (int i = 0; i < 16; i++) begin wr_en = 1'b1; wr_data = 16'h0C00 + 16'(i); tick(); end
    wr_en = 1'b0; rd_enable = 1'b1; init_done = 1'b1;
    wexp = 0;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin if (wr_req === 1'b1 || rd_req === 1'b1) begin got = 1'b1; break; end tick(); end
      checks++; if ({wr_req, rd_req} !== {exp_w[g], !exp_w[g]}) begin failures++; $display("FAIL arb_grant[%0d] got wr=%0b rd=%0b exp wr=%0b rd=%0b", g, wr_req, rd_req, exp_w[g], !exp_w[g]); end
      checks++; if ((exp_w[g] ? wr_addr : rd_addr) !== exp_a[g]) begin failures++; $display("FAIL arb_addr[%0d] got=%0h exp=%0h", g, exp_w[g] ? wr_addr : rd_addr, exp_a[g]); end
      if (got && wr_req === 1'b1) begin
        for (int i = 0; i < 8; i++) begin
          wr_ack = 1'b1;
          checks++; if (din !== 16'h0C00 + 16'(wexp)) begin failures++; $display("FAIL arb_wr_din[%0d] got=%0h exp=%0h", wexp, din, 16'h0C00 + 16'(wexp)); end
          wexp++;
          tick();
        end
        wr_ack = 1'b0; tick();
      end else if (got) begin
        for (int i = 0; i < 8; i++) begin rd_ack = 1'b1; dout = 16'hB000 + 16'(i); tick(); end
        rd_ack = 1'b0; tick();
      end
    end
    rd_enable = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic        got;
    logic [23:0] exp_a [3] = '{24'd0, 24'd8, 24'd0};
    w_rst_n = 1'b0; tick(); w_rst_n = 1'b1;
    w_init = 1'b0;
    for (int i = 0; i < 24; i++) begin w_wr_en = 1'b1; w_wr_data = 16'h0D00 + 16'(i); tick(); end
    w_wr_en = 1'b0; w_init = 1'b1;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin if (w_wr_req === 1'b1) begin got = 1'b1; break; end tick(); end
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL wrap_req[%0d] got=%0b exp=1", k, got); end
      checks++; if (w_wr_addr !== exp_a[k]) begin failures++; $display("FAIL wrap_addr[%0d] got=%0h exp=%0h", k, w_wr_addr, exp_a[k]); end
      if (got) begin
        for (int i = 0; i < 8; i++) begin w_wr_ack = 1'b1; tick(); end
        w_wr_ack = 1'b0; tick();
      end
    end
    checks++; if (w_wr_addr !== 24'd8) begin failures++; $display("FAIL wrap_final_addr got=%0h exp=8", w_wr_addr); end
    w_init = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic got;
    do_reset();
    init_done = 1'b0;
    for (int i = 0; i < 16; i++) begin wr_en = 1'b1; wr_data = 16'h0E00 + 16'(i); tick(); end
    wr_en = 1'b0; init_done = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 4; c++) begin if (wr_req === 1'b1) begin got = 1'b1; break; end tick(); end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%0b exp=1", got); end
    wr_ack = 1'b1; init_done = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++; if (wr_req !== 1'b0 || rd_req !== 1'b0) begin failures++; $display("FAIL rstmid_req_clr got wr=%0b rd=%0b exp 0/0", wr_req, rd_req); end
    checks++; if (din !== 16'h0 || wr_addr !== 24'd0) begin failures++; $display("FAIL rstmid_state got din=%0h addr=%0h exp 0/0", din, wr_addr); end
    checks++; if (wr_full !== 1'b0 || rd_empty !== 1'b1) begin failures++; $display("FAIL rstmid_flags got full=%0b empty=%0b exp 0/1", wr_full, rd_empty); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 16'h0B01 + 16'(i); rd_ack = 1'b1; dout = 16'hDEAD; tick();
    end
    wr_en = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
    tick();
    checks++; if (dut.wr_fill !== 6'd5) begin failures++; $display("FAIL trail_ack_wr_fill got=%0d exp=5", dut.wr_fill); end
    checks++; if (din !== 16'h0B01) begin failures++; $display("FAIL trail_ack_head got=%0h exp=0b01", din); end
    checks++; if (rd_empty !== 1'b1) begin failures++; $display("FAIL trail_ack_rd_push got=%0b exp=1", rd_empty); end
    for (int i = 0; i < 27; i++) begin wr_en = 1'b1; wr_data = 16'h0F00 + 16'(i); tick(); end
    wr_en = 1'b0;
    checks++; if (wr_full !== 1'b1) begin failures++; $display("FAIL wr_full_flag got=%0b exp=1", wr_full); end
    wr_en = 1'b1; wr_data = 16'hFFFF; tick(); wr_en = 1'b0;
    checks++; if (dut.wr_fill !== 6'd32 || din !== 16'h0B01) begin failures++; $display("FAIL wr_full_ignore got fill=%0d head=%0h exp 32/0b01", dut.wr_fill, din); end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rd_enable = 1'b0; init_done = 1'b0;
    wr_ack = 1'b0; rd_ack = 1'b0; dout = '0;
    w_rst_n = 1'b0; w_wr_en = 1'b0; w_wr_data = '0; w_init = 1'b0; w_wr_ack = 1'b0;
    test_reset();
    test_init_gate();
    test_write_burst();
    test_read_prefetch();
    test_arbitration();
    test_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
